seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl_pkg.sv | 14 +
 rtl/seg_scan_ctrl_decode.sv | 13 +
 rtl/seg_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

    typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7f;

    // Active-low {g..a} codes; entry [n] is the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// Hex nibble to active-low 7-segment pattern, shared by all scanned digits.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nib];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with dead-time blanking,
// leading-zero suppression and frame-synchronous double-buffered display data.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG      = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                clkin,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [4*NDIG-1:0]   data,
    input  logic [NDIG-1:0]     dig_en,
    input  logic                lz_blank,
    output logic [6:0]          seg,
    output logic [NDIG-1:0]     an,
    output logic                frame_done
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(SCAN_DIV);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;

    logic [4*NDIG-1:0] pend_data, act_data;
    logic [NDIG-1:0]   pend_den, act_den;
    logic              pend_lz, act_lz;
    logic              pend_valid;
    logic              commit;

    logic [NDIG-1:0]   vis;
    logic [NDIG-1:0]   an_sel;
    logic [3:0]        cur_nib;
    logic [6:0]        cur_seg;
    logic              all_zero;

    assign commit = (state == OFF) ||
                    (en && state == SHOW && cnt == SLOT_LAST && idx == IDX_LAST);

    // A load landing on a commit edge goes straight to the active buffer.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            pend_data  <= '0;
            pend_den   <= '0;
            pend_lz    <= 1'b0;
            act_data   <= '0;
            act_den    <= '0;
            act_lz     <= 1'b0;
            pend_valid <= 1'b0;
        end else begin
            if (load) begin
                pend_data <= data;
                pend_den  <= dig_en;
                pend_lz   <= lz_blank;
            end
            if (commit) begin
                if (load) begin
                    act_data <= data;
                    act_den  <= dig_en;
                    act_lz   <= lz_blank;
                end else if (pend_valid) begin
                    act_data <= pend_data;
                    act_den  <= pend_den;
                    act_lz   <= pend_lz;
                end
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // Walk from the most significant digit down, tracking the all-zero prefix.
    always_comb begin
        all_zero = 1'b1;
        vis      = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            all_zero = all_zero && (act_data[4*(NDIG-1-k) +: 4] == 4'h0);
            vis[NDIG-1-k] = act_den[NDIG-1-k] &&
                            !(act_lz && (k != NDIG-1) && all_zero);
        end
    end

    always_comb begin
        cur_nib = '0;
        an_sel  = '1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (idx == IW'(k)) begin
                cur_nib   = act_data[4*k +: 4];
                an_sel[k] = !vis[k];
            end
        end
    end

    seg7_decode u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

    // cnt runs 0..SCAN_DIV-1 across the whole slot; BLANK covers the low part.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state      <= OFF;
            idx        <= '0;
            cnt        <= '0;
            seg        <= SEG_BLANK;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!en) begin
                state <= OFF;
                idx   <= '0;
                cnt   <= '0;
                seg   <= SEG_BLANK;
                an    <= '1;
            end else begin
                case (state)
                    OFF: begin
                        state <= BLANK;
                        idx   <= '0;
                        cnt   <= '0;
                        seg   <= SEG_BLANK;
                        an    <= '1;
                    end
                    BLANK: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == BLANK_LAST) begin
                            state <= SHOW;
                            seg   <= cur_seg;
                            an    <= an_sel;
                        end
                    end
                    SHOW: begin
                        if (cnt == SLOT_LAST) begin
                            state <= BLANK;
                            cnt   <= '0;
                            seg   <= SEG_BLANK;
                            an    <= '1;
                            if (idx == IDX_LAST) begin
                                idx        <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= OFF;
                        idx   <= '0;
                        cnt   <= '0;
                        seg   <= SEG_BLANK;
                        an    <= '1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=4, SCAN_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

    localparam logic [6:0] BL = 7'h7f;

    logic        clkin;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dig_en;
    logic        lz_blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      den;
        logic            lz;
        logic [3:0][3:0] anx;
        logic [3:0][6:0] segx;
    } vec_t;

    vec_t vecs [7];

    seg_scan_ctrl #(
        .NDIG      (4),
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data       (data),
        .dig_en     (dig_en),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick_chk(input logic [3:0] ea, input logic [6:0] es, input logic efd);
        @(posedge clkin);
        #1;
        load = 1'b0;
        chk("an", {12'h0, an}, {12'h0, ea});
        chk("seg", {9'h0, seg}, {9'h0, es});
        chk("frame_done", {15'h0, frame_done}, {15'h0, efd});
    endtask

    task automatic slot_head(input logic [3:0] ea, input logic [6:0] es);
        tick_chk(4'hF, BL, 1'b0);
        for (int c = 2; c <= 7; c++) tick_chk(ea, es, 1'b0);
    endtask

    task automatic slot_tail(input logic efd);
        tick_chk(4'hF, BL, efd);
    endtask

    task automatic slot(input logic [3:0] ea, input logic [6:0] es, input logic efd);
        slot_head(ea, es);
        slot_tail(efd);
    endtask

    // Stop scanning, load new contents, let OFF commit them, then enable.
    task automatic start(input logic [15:0] d, input logic [3:0] de, input logic lz);
        en       = 1'b0;
        load     = 1'b1;
        data     = d;
        dig_en   = de;
        lz_blank = lz;
        tick_chk(4'hF, BL, 1'b0);
        tick_chk(4'hF, BL, 1'b0);
        en = 1'b1;
        tick_chk(4'hF, BL, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        data     = '0;
        dig_en   = '0;
        lz_blank = 1'b0;

        vecs[0] = '{16'h1234, 4'hF, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'h0050, 4'hF, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {7'h40, 7'h40, 7'h12, 7'h40}};
        vecs[2] = '{16'h0000, 4'hF, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[3] = '{16'hCDEF, 4'h5, 1'b0, {4'b1111, 4'b1011, 4'b1111, 4'b1110}, {7'h46, 7'h21, 7'h06, 7'h0E}};
        vecs[4] = '{16'h0800, 4'hF, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110}, {7'h40, 7'h00, 7'h40, 7'h40}};
        vecs[5] = '{16'h0000, 4'hE, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1111}, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[6] = '{16'h9B7A, 4'hF, 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h10, 7'h03, 7'h78, 7'h08}};

        // Reset state before any clock edge.
        #2;
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, {9'h0, BL});
        chk("rst_fd", {15'h0, frame_done}, 16'h0);
        #10;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick_chk(4'hF, BL, 1'b0);

        // Table-driven full frames.
        for (int v = 0; v < 7; v++) begin
            start(vecs[v].data, vecs[v].den, vecs[v].lz);
            for (int s = 0; s < 4; s++)
                slot(vecs[v].anx[s], vecs[v].segx[s], s == 3);
        end

        // Mid-frame load affects only the following frame.
        start(16'h1234, 4'hF, 1'b0);
        slot(4'b1110, 7'h19, 1'b0);
        load = 1'b1; data = 16'hAAAA; dig_en = 4'hF; lz_blank = 1'b0;
        slot(4'b1101, 7'h30, 1'b0);
        slot(4'b1011, 7'h24, 1'b0);
        slot(4'b0111, 7'h79, 1'b1);
        slot(4'b1110, 7'h08, 1'b0);
        slot(4'b1101, 7'h08, 1'b0);

        // Load on the frame-boundary edge overrides an older pending value.
        start(16'h1234, 4'hF, 1'b0);
        slot(4'b1110, 7'h19, 1'b0);
        load = 1'b1; data = 16'h5555;
        slot(4'b1101, 7'h30, 1'b0);
        slot(4'b1011, 7'h24, 1'b0);
        slot_head(4'b0111, 7'h79);
        load = 1'b1; data = 16'h6666;
        slot_tail(1'b1);
        slot(4'b1110, 7'h02, 1'b0);
        slot(4'b1101, 7'h02, 1'b0);

        // en dropped on the final SHOW cycle of the frame: no frame_done.
        start(16'h1234, 4'hF, 1'b0);
        slot(4'b1110, 7'h19, 1'b0);
        slot(4'b1101, 7'h30, 1'b0);
        slot(4'b1011, 7'h24, 1'b0);
        slot_head(4'b0111, 7'h79);
        en = 1'b0;
        for (int i = 0; i < 3; i++) tick_chk(4'hF, BL, 1'b0);
        en = 1'b1;
        tick_chk(4'hF, BL, 1'b0);
        slot(4'b1110, 7'h19, 1'b0);
        tick_chk(4'hF, BL, 1'b0);
        tick_chk(4'b1101, 7'h30, 1'b0);
        en = 1'b0;
        tick_chk(4'hF, BL, 1'b0);

        // Asynchronous reset in the middle of a SHOW slot.
        start(16'h1234, 4'hF, 1'b0);
        tick_chk(4'hF, BL, 1'b0);
        tick_chk(4'b1110, 7'h19, 1'b0);
        tick_chk(4'b1110, 7'h19, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_an", {12'h0, an}, 16'h000F);
        chk("async_seg", {9'h0, seg}, {9'h0, BL});
        chk("async_fd", {15'h0, frame_done}, 16'h0);
        @(posedge clkin);
        #1;
        en  = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick_chk(4'hF, BL, 1'b0);
        // Buffers were cleared: every digit disabled, nibble 0 decoded.
        en = 1'b1;
        tick_chk(4'hF, BL, 1'b0);
        slot(4'hF, 7'h40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
